// File: rtl/car_pkg.sv
// Shared encodings for the car drive path: tracker commands, wheel direction
// codes, sequencer states and the per-wheel command payload.
package car_pkg;

    localparam int unsigned DUTY_W = 10;

    localparam logic [2:0] TRK_LEFT        = 3'd0;
    localparam logic [2:0] TRK_RIGHT       = 3'd1;
    localparam logic [2:0] TRK_STRAIGHT    = 3'd2;
    localparam logic [2:0] TRK_STOP        = 3'd3;
    localparam logic [2:0] TRK_SHARP_LEFT  = 3'd4;
    localparam logic [2:0] TRK_SHARP_RIGHT = 3'd5;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_OFF = 2'b00;

    typedef enum logic [2:0] {
        SEQ_RUN    = 3'd0,
        SEQ_BRAKE  = 3'd1,
        SEQ_SEARCH = 3'd2,
        SEQ_HALT   = 3'd3
    } seq_state_t;

    typedef enum logic {
        TURN_LEFT  = 1'b0,
        TURN_RIGHT = 1'b1
    } turn_t;

    typedef struct packed {
        logic [1:0]        left;
        logic [1:0]        right;
        logic [DUTY_W-1:0] target_left;
        logic [DUTY_W-1:0] target_right;
    } drive_cmd_t;

endpackage

// File: rtl/duty_ramp.sv
// Per-wheel PWM duty shaper: soft ramp up on ticks, immediate decrease,
// and a restart from zero whenever the wheel starts, stops or reverses.
module duty_ramp
    import car_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        dir,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty
);

    logic [1:0]        dir_q;
    logic [DUTY_W-1:0] duty_d;
    logic [31:0]       stepped;
    logic              restart;

    // A wheel that is off, was off, or flips direction begins again at zero
    always_comb begin
        restart = (dir == DIR_OFF) || (dir_q == DIR_OFF) || (dir != dir_q);
        stepped = 32'(duty) + 32'(RAMP_STEP);
        duty_d  = duty;
        if (restart) begin
            duty_d = '0;
        end else if (target <= duty) begin
            duty_d = target;
        end else if (tick) begin
            duty_d = (stepped >= 32'(target)) ? target : DUTY_W'(stepped);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty  <= '0;
            dir_q <= DIR_OFF;
        end else begin
            duty  <= duty_d;
            dir_q <= dir;
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// Drive sequencer: arbitrates tracker steering against obstacle stop and line
// loss, and feeds ramped duty targets to both wheel PWM channels.
module drive_sequencer
    import car_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned RAMP_STEP    = 16,
    parameter int unsigned DUTY_FWD     = 1000,
    parameter int unsigned DUTY_TURN    = 900,
    parameter int unsigned DUTY_SHARP   = 800,
    parameter int unsigned DUTY_SEARCH  = 700,
    parameter int unsigned CLEAR_TICKS  = 200,
    parameter int unsigned LOST_TICKS   = 50,
    parameter int unsigned SEARCH_TICKS = 3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        track_state,
    input  logic              sonic_stop,
    output logic [1:0]        left,
    output logic [1:0]        right,
    output logic [DUTY_W-1:0] duty_left,
    output logic [DUTY_W-1:0] duty_right,
    output logic [2:0]        seq_state
);

    localparam int unsigned PRESC_W  = $clog2(TICK_DIV);
    localparam int unsigned CLEAR_W  = $clog2(CLEAR_TICKS) + 1;
    localparam int unsigned LOST_W   = $clog2(LOST_TICKS) + 1;
    localparam int unsigned SEARCH_W = $clog2(SEARCH_TICKS) + 1;

    seq_state_t          state, state_d;
    turn_t               last_turn, last_turn_d;
    logic [PRESC_W-1:0]  presc;
    logic [CLEAR_W-1:0]  clear_cnt, clear_d, clear_inc;
    logic [LOST_W-1:0]   lost_cnt, lost_d, lost_inc;
    logic [SEARCH_W-1:0] search_cnt, search_d, search_inc;
    logic                tick_c;
    logic                stop_c;
    drive_cmd_t          cmd;

    function automatic drive_cmd_t steer_map(input logic [2:0] trk);
        case (trk)
            TRK_LEFT:        return '{DIR_OFF, DIR_FWD, '0, DUTY_W'(DUTY_TURN)};
            TRK_SHARP_LEFT:  return '{DIR_REV, DIR_FWD, DUTY_W'(DUTY_SHARP), DUTY_W'(DUTY_SHARP)};
            TRK_RIGHT:       return '{DIR_FWD, DIR_OFF, DUTY_W'(DUTY_TURN), '0};
            TRK_SHARP_RIGHT: return '{DIR_FWD, DIR_REV, DUTY_W'(DUTY_SHARP), DUTY_W'(DUTY_SHARP)};
            TRK_STRAIGHT:    return '{DIR_FWD, DIR_FWD, DUTY_W'(DUTY_FWD), DUTY_W'(DUTY_FWD)};
            default:         return '{DIR_OFF, DIR_OFF, '0, '0};
        endcase
    endfunction

    assign tick_c    = (presc == PRESC_W'(TICK_DIV - 1));
    assign stop_c    = (track_state == TRK_STOP) || (track_state > TRK_SHARP_RIGHT);
    assign seq_state = state;

    // Next state, saturating tick counters and the wheel command for next cycle
    always_comb begin
        state_d     = state;
        last_turn_d = last_turn;
        lost_d      = '0;
        clear_d     = '0;
        search_d    = '0;
        cmd         = '0;
        lost_inc    = (lost_cnt >= LOST_W'(LOST_TICKS)) ? lost_cnt : lost_cnt + LOST_W'(1);
        clear_inc   = (clear_cnt >= CLEAR_W'(CLEAR_TICKS)) ? clear_cnt : clear_cnt + CLEAR_W'(1);
        search_inc  = (search_cnt >= SEARCH_W'(SEARCH_TICKS)) ? search_cnt
                                                              : search_cnt + SEARCH_W'(1);
        case (state)
            SEQ_RUN: begin
                if (track_state == TRK_LEFT || track_state == TRK_SHARP_LEFT) begin
                    last_turn_d = TURN_LEFT;
                end else if (track_state == TRK_RIGHT || track_state == TRK_SHARP_RIGHT) begin
                    last_turn_d = TURN_RIGHT;
                end
                if (stop_c) begin
                    lost_d = tick_c ? lost_inc : lost_cnt;
                end
                if (sonic_stop) begin
                    state_d = SEQ_BRAKE;
                end else if (lost_d >= LOST_W'(LOST_TICKS)) begin
                    state_d = SEQ_SEARCH;
                end
            end
            SEQ_BRAKE: begin
                if (!sonic_stop) begin
                    clear_d = tick_c ? clear_inc : clear_cnt;
                end
                if (clear_d >= CLEAR_W'(CLEAR_TICKS)) begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_SEARCH: begin
                search_d = tick_c ? search_inc : search_cnt;
                if (sonic_stop) begin
                    state_d = SEQ_BRAKE;
                end else if (!stop_c) begin
                    state_d = SEQ_RUN;
                end else if (search_d >= SEARCH_W'(SEARCH_TICKS)) begin
                    state_d = SEQ_HALT;
                end
            end
            SEQ_HALT: state_d = SEQ_HALT;
            default:  state_d = SEQ_RUN;
        endcase

        case (state_d)
            SEQ_RUN: cmd = steer_map(track_state);
            SEQ_SEARCH: begin
                if (last_turn == TURN_LEFT) begin
                    cmd = '{DIR_REV, DIR_FWD, DUTY_W'(DUTY_SEARCH), DUTY_W'(DUTY_SEARCH)};
                end else begin
                    cmd = '{DIR_FWD, DIR_REV, DUTY_W'(DUTY_SEARCH), DUTY_W'(DUTY_SEARCH)};
                end
            end
            default: cmd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEQ_RUN;
            last_turn  <= TURN_LEFT;
            presc      <= '0;
            clear_cnt  <= '0;
            lost_cnt   <= '0;
            search_cnt <= '0;
            left       <= DIR_OFF;
            right      <= DIR_OFF;
        end else begin
            state      <= state_d;
            last_turn  <= last_turn_d;
            presc      <= tick_c ? '0 : presc + PRESC_W'(1);
            clear_cnt  <= clear_d;
            lost_cnt   <= lost_d;
            search_cnt <= search_d;
            left       <= cmd.left;
            right      <= cmd.right;
        end
    end

    duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_left (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick_c),
        .dir    (cmd.left),
        .target (cmd.target_left),
        .duty   (duty_left)
    );

    duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_right (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick_c),
        .dir    (cmd.right),
        .target (cmd.target_right),
        .duty   (duty_right)
    );

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with a 4-cycle tick; expected values are
// hand-derived cycle by cycle from reset release.
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] track_state = 3'd2;
    logic       sonic_stop = 1'b0;
    logic [1:0] left, right;
    logic [9:0] duty_left, duty_right;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    drive_sequencer #(
        .TICK_DIV     (4),
        .RAMP_STEP    (256),
        .DUTY_FWD     (1000),
        .DUTY_SEARCH  (700),
        .CLEAR_TICKS  (3),
        .LOST_TICKS   (2),
        .SEARCH_TICKS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .track_state (track_state),
        .sonic_stop  (sonic_stop),
        .left        (left),
        .right       (right),
        .duty_left   (duty_left),
        .duty_right  (duty_right),
        .seq_state   (seq_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int seq, input int dirs,
                             input int dl, input int dr);
        check({tag, ".seq"},   int'(seq_state), seq);
        check({tag, ".dirs"},  int'({left, right}), dirs);
        check({tag, ".dutyl"}, int'(duty_left), dl);
        check({tag, ".dutyr"}, int'(duty_right), dr);
    endtask

    // Comments give the cycle count after reset release (R) or the later reset (S)
    initial begin
        step(3);
        check_out("reset", 0, 'b0000, 0, 0);
        rst = 1'b0;
        step(1);  check_out("fwd_r1", 0, 'b1010, 0, 0);
        step(2);  check_out("fwd_r3", 0, 'b1010, 0, 0);
        step(1);  check_out("fwd_r4", 0, 'b1010, 256, 256);
        step(4);  check_out("fwd_r8", 0, 'b1010, 512, 512);
        step(4);  check_out("fwd_r12", 0, 'b1010, 768, 768);
        step(4);  check_out("fwd_r16", 0, 'b1010, 1000, 1000);
        step(4);  check_out("fwd_r20", 0, 'b1010, 1000, 1000);

        track_state = 3'd4;
        step(1);  check_out("sharp_r21", 0, 'b0110, 0, 800);
        step(3);  check_out("sharp_r24", 0, 'b0110, 256, 800);
        step(4);  check_out("sharp_r28", 0, 'b0110, 512, 800);
        step(4);  check_out("sharp_r32", 0, 'b0110, 768, 800);
        step(4);  check_out("sharp_r36", 0, 'b0110, 800, 800);

        track_state = 3'd2;
        step(1);  check_out("rev_r37", 0, 'b1010, 0, 800);
        step(3);  check_out("sat_r40", 0, 'b1010, 256, 1000);

        sonic_stop = 1'b1;
        step(1);  check_out("brake_r41", 1, 'b0000, 0, 0);
        sonic_stop = 1'b0;
        step(7);  check_out("brake_r48", 1, 'b0000, 0, 0);
        sonic_stop = 1'b1;
        step(1);
        sonic_stop = 1'b0;
        step(7);  check_out("brake_restart_r56", 1, 'b0000, 0, 0);
        step(4);  check_out("resume_r60", 0, 'b1010, 0, 0);
        step(4);  check_out("resume_r64", 0, 'b1010, 256, 256);

        track_state = 3'd1;
        step(1);  check_out("right_r65", 0, 'b1000, 256, 0);
        track_state = 3'd3;
        step(1);  check_out("stop_r66", 0, 'b0000, 0, 0);
        step(5);  check_out("lost_r71", 0, 'b0000, 0, 0);
        step(1);  check_out("search_r72", 2, 'b1001, 0, 0);
        step(4);  check_out("search_r76", 2, 'b1001, 256, 256);
        step(8);  check_out("search_r84", 2, 'b1001, 700, 700);
        step(4);  check_out("search_r88", 2, 'b1001, 700, 700);

        track_state = 3'd0;
        step(1);  check_out("regain_r89", 0, 'b0010, 0, 0);
        step(1);  check_out("regain_r90", 0, 'b0010, 0, 0);
        track_state = 3'd3;
        step(6);  check_out("search_l_r96", 2, 'b0110, 0, 0);
        step(28); check_out("search_l_r124", 2, 'b0110, 700, 700);
        step(4);  check_out("halt_r128", 3, 'b0000, 0, 0);

        sonic_stop = 1'b1;
        step(3);
        sonic_stop = 1'b0;
        step(2);
        track_state = 3'd2;
        step(2);
        sonic_stop = 1'b1;
        step(1);
        sonic_stop = 1'b0;
        step(8);  check_out("halt_held", 3, 'b0000, 0, 0);

        rst = 1'b1;
        step(1);  check_out("halt_reset", 0, 'b0000, 0, 0);
        rst = 1'b0;
        track_state = 3'd3;
        step(7);  check_out("lost_s7", 0, 'b0000, 0, 0);
        sonic_stop = 1'b1;
        step(1);  check_out("sonic_prio_s8", 1, 'b0000, 0, 0);
        sonic_stop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Sits between the line tracker / ultrasonic stop logic and the two motor PWM channels.
- Arbitrates the tracker steering command against obstacle stop and line loss, and sequences the wheel direction codes.
- Generates ramped PWM duty targets: soft-start, brake, clear-delay, lost-line search and terminal halt.
- Replaces the direct combinational steering decode in the top level.

Parameters:
- TICK_DIV, 100000: clk cycles per sequencing tick (1 kHz at 100 MHz); range 2..2^20.
- RAMP_STEP, 16: duty increment per tick while accelerating.
- DUTY_FWD, 1000: target duty, both wheels, go_straight.
- DUTY_TURN, 900: outer-wheel target duty, gentle turn.
- DUTY_SHARP, 800: target duty, both wheels, sharp turn.
- DUTY_SEARCH, 700: both-wheel duty during SEARCH spin.
- CLEAR_TICKS, 200: consecutive ticks sonic_stop must be low before leaving BRAKE.
- LOST_TICKS, 50: consecutive ticks of track_state==stop before entering SEARCH.
- SEARCH_TICKS, 3000: SEARCH timeout in ticks before HALT.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- track_state, in, 3: tracker command. 0 turn_left, 1 turn_right, 2 go_straight, 3 stop, 4 sharp_turn_left, 5 sharp_turn_right; 6 and 7 are treated as stop.
- sonic_stop, in, 1: obstacle-close flag, level.
- left, out, 2: left wheel direction. 2'b10 forward, 2'b01 reverse, 2'b00 off.
- right, out, 2: right wheel direction, same encoding as left.
- duty_left, out, 10: left PWM duty, 0..1023.
- duty_right, out, 10: right PWM duty, 0..1023.
- seq_state, out, 3: current FSM state, for LEDs and debug.

Behaviour:
- Reset: left=right=2'b00, duty_left=duty_right=0, FSM=RUN, tick prescaler=0, all tick counters=0, last_turn=LEFT.
  - rst mid-operation overrides everything, including HALT, on the next edge.
- Tick: one-cycle pulse when the prescaler reaches TICK_DIV-1; the prescaler then wraps to 0.
  - All *_TICKS counting and ramping happen only on tick cycles.
- Outputs are registered. An input change is reflected on the outputs 1 cycle later, except ramp steps, which occur on ticks.
- Steering map in RUN, as {left,right}:
  - turn_left: 0010. Left duty target 0; right duty target DUTY_TURN.
  - sharp_turn_left: 0110. Both duty targets DUTY_SHARP.
  - turn_right: 1000. Left target DUTY_TURN; right target 0.
  - sharp_turn_right: 1001. Both targets DUTY_SHARP.
  - go_straight: 1010. Both targets DUTY_FWD.
  - stop (or 6/7): 0000. Both targets 0.
- Turn memory: any left-turn command sets last_turn=LEFT; any right-turn command sets last_turn=RIGHT. Updated in RUN only.
- Ramp, per wheel:
  - A target below the current duty is applied immediately, on the next cycle.
  - A target above the current duty is approached by +RAMP_STEP per tick, saturating exactly at the target with no overshoot.
  - A direction code that reverses (10<->01) forces that wheel's duty to 0 in the same cycle the code changes; the ramp restarts from 0.
  - A wheel whose code is 00 always has duty 0.
- FSM states: RUN=0, BRAKE=1, SEARCH=2, HALT=3.
  - RUN:
    - sonic_stop=1 -> BRAKE, next cycle, without waiting for a tick.
    - Else, LOST_TICKS consecutive ticks with track_state==stop -> SEARCH.
    - The lost counter clears on any non-stop command.
  - BRAKE:
    - Outputs 0000 and duties 0 from the first cycle in BRAKE.
    - The clear counter counts ticks while sonic_stop=0 and clears to 0 whenever sonic_stop=1.
    - Reaching CLEAR_TICKS -> RUN, with duties starting at 0 (soft start).
  - SEARCH:
    - Pivot toward last_turn: LEFT gives 0110, RIGHT gives 1001. Duties ramp to DUTY_SEARCH.
    - track_state != stop -> RUN, next cycle, taking that command.
    - sonic_stop=1 -> BRAKE.
    - SEARCH_TICKS ticks elapsed -> HALT.
  - HALT: 0000, duties 0. Left only by rst; sonic_stop is ignored.
- Simultaneous events:
  - sonic_stop has priority over every RUN/SEARCH transition.
  - A line regained on the same cycle SEARCH times out takes RUN.
- Counters saturate and never wrap. Widths are sized by $clog2 of their parameter +1.

Decomposition:
- Shared package car_pkg holds:
  - track_state encodings (currently per-module parameters),
  - direction codes DIR_FWD/DIR_REV/DIR_OFF,
  - seq_state encodings,
  - the 10-bit duty width constant.
- Natural sub-module: duty_ramp, instantiated once per wheel.
  - Inputs: clk, rst, tick, dir, target.
  - Output: duty.
  - Owns the ramp, fast-decrease and reversal-zero rules.
- Prescaler and FSM stay in drive_sequencer.

Test Plan:
Bench parameters: TICK_DIV=4, RAMP_STEP=256, DUTY_FWD=1000, CLEAR_TICKS=3, LOST_TICKS=2, SEARCH_TICKS=8, DUTY_SEARCH=700.
- Reset, then hold go_straight -> {left,right}=1010 one cycle after reset release; duties 0, 256, 512, 768, 1000, changing on successive ticks, then hold at 1000.
- At steady 1000, switch to sharp_turn_left -> next cycle 0110; duty_left=0, ramps 256/512/768/800; duty_right drops to 800 next cycle.
- sonic_stop=1 for 1 cycle mid-ramp -> next cycle seq_state=1, outputs 0000, duty 0. Pulse sonic_stop again after 2 clear ticks -> counter restarts. RUN resumes only after 3 clean ticks, duty ramping from 0.
- After a right turn, hold stop for 2 ticks -> SEARCH, 1001, duties ramp to 700. Apply turn_left -> RUN with 0010 next cycle.
- Hold stop through SEARCH for 8 ticks -> seq_state=3, 0000. sonic_stop toggling and go_straight are both ignored until rst. rst -> RUN, 0000, duties 0.
- sonic_stop=1 on the same cycle the LOST_TICKS threshold is reached -> BRAKE, not SEARCH.
